// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller for the single-cycle 9-bit-instruction CPU.
// It owns the program counter and sequences a run from the start handshake
// through to halt. On each RUN cycle it applies the decoder Branch/Halt outputs
// and the ALU compare result.
//
// Parameters:
//   D          - program counter width (instruction ROM depth is 2^D)
//   START_ADDR - PC loaded on reset and on every re-arm
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset, highest priority
//   start    in   level; run requested while high, begins when it falls
//   branch   in   decoder Branch for the instruction at pc
//   halt     in   decoder Halt for the instruction at pc
//   taken    in   ALU compare result (branch condition holds)
//   target   in   absolute branch destination [D-1:0]
//   stall    in   hold pc and suppress halt/branch decisions this cycle
//   pc       out  registered program counter / ROM address [D-1:0]
//   fetch_en out  high while in RUN
//   done     out  registered, high while in HALT
//   cycles   out  32-bit saturating RUN-cycle counter
//                 (only when PC_SEQ_CYCLE_COUNT_EN is defined)
//
// Optional feature macro: PC_SEQ_CYCLE_COUNT_EN.

module pc_sequencer #(
    parameter int unsigned D          = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         branch,
    input  logic         halt,
    input  logic         taken,
    input  logic [D-1:0] target,
    input  logic         stall,
    output logic [D-1:0] pc,
    output logic         fetch_en,
    output logic         done
`ifdef PC_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]  cycles
`endif
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] PC_ONE   = D'(1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRun,
        StHalt
    } state_t;

    state_t state;
    logic   start_q;   // previous start level, for rising-edge detection in RUN
    logic   to_armed;  // this edge enters ARMED

    always_comb begin
        to_armed = 1'b0;
        case (state)
            StIdle:  to_armed = start;
            StRun:   to_armed = start && !start_q;
            StHalt:  to_armed = start;
            default: to_armed = 1'b0;
        endcase
    end

    assign fetch_en = (state == StRun);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            pc      <= START_PC;
            done    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                StIdle: begin
                    pc <= START_PC;
                    if (to_armed) begin
                        state <= StArmed;
                    end
                end
                StArmed: begin
                    pc <= START_PC;
                    if (!start) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    // An abort/re-arm outranks both stall and halt.
                    if (to_armed) begin
                        state <= StArmed;
                        pc    <= START_PC;
                    end else if (!stall) begin
                        if (halt) begin
                            // pc stays on the halt instruction
                            state <= StHalt;
                            done  <= 1'b1;
                        end else if (branch && taken) begin
                            pc <= target;
                        end else begin
                            pc <= pc + PC_ONE;  // wraps modulo 2^D
                        end
                    end
                end
                StHalt: begin
                    if (to_armed) begin
                        state <= StArmed;
                        done  <= 1'b0;
                        pc    <= START_PC;
                    end
                end
                default: begin
                    state <= StIdle;
                    pc    <= START_PC;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    // Counts every edge taken while in RUN, stalls included; entry to ARMED
    // restarts it and it holds in HALT/IDLE so the count is readable after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= 32'd0;
        end else if (to_armed) begin
            cycles <= 32'd0;
        end else if ((state == StRun) && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       branch;
    logic       halt;
    logic       taken;
    logic [9:0] target;
    logic       stall;
    logic [9:0] pc;
    logic       fetch_en;
    logic       done;
`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycles;
`endif

    pc_sequencer #(
        .D          (10),
        .START_ADDR (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .branch   (branch),
        .halt     (halt),
        .taken    (taken),
        .target   (target),
        .stall    (stall),
        .pc       (pc),
        .fetch_en (fetch_en),
        .done     (done)
`ifdef PC_SEQ_CYCLE_COUNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic        br;
        logic        ha;
        logic        tk;
        logic        sl;
        logic [9:0]  tg;
        logic [9:0]  epc;
        logic        efe;
        logic        edone;
        logic [31:0] ecyc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [9:0]  epc;
        logic        efe;
        logic        edone;
        logic [31:0] ecyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   applied = 0;

    function automatic vec_t mk(logic rst, logic st, logic br, logic ha, logic tk, logic sl,
                                logic [9:0] tg, logic [9:0] epc, logic efe, logic edone,
                                logic [31:0] ecyc);
        vec_t v;
        v.rst = rst; v.st = st; v.br = br; v.ha = ha; v.tk = tk; v.sl = sl; v.tg = tg;
        v.epc = epc; v.efe = efe; v.edone = edone; v.ecyc = ecyc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, required %0h", name, idx, act, exp);
        end
    endtask

    // Drive one record before the edge, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset  = v.rst;
        start  = v.st;
        branch = v.br;
        halt   = v.ha;
        taken  = v.tk;
        stall  = v.sl;
        target = v.tg;
        e.idx = applied; e.epc = v.epc; e.efe = v.efe; e.edone = v.edone; e.ecyc = v.ecyc;
        sb.push_back(e);
        applied++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", e.idx, 32'(pc), 32'(e.epc));
        check("fetch_en", e.idx, 32'(fetch_en), 32'(e.efe));
        check("done", e.idx, 32'(done), 32'(e.edone));
`ifdef PC_SEQ_CYCLE_COUNT_EN
        check("cycles", e.idx, cycles, e.ecyc);
`endif
    endtask

    initial begin
        logic [9:0]  pc_m;
        logic [31:0] cyc_m;

        reset = 1'b1; start = 1'b0; branch = 1'b0; halt = 1'b0;
        taken = 1'b0; stall = 1'b0; target = '0;

        //            rst st br ha tk sl target   pc      fe dn cyc
        // straight-line run, halt at 5
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd1,   1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd2,   1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd3,   1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd4,   1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd5,   1, 0, 5));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 10'h000, 10'd5,   0, 1, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd5,   0, 1, 6));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 10'h123, 10'd5,   0, 1, 6));
        // re-arm from HALT, taken/not-taken branches at pc 3, halt beats branch
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd1,   1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd2,   1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd3,   1, 0, 3));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 10'h2A0, 10'h2A0, 1, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 10'h003, 10'd3,   1, 0, 5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 10'h2A0, 10'd4,   1, 0, 6));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 10'h100, 10'd4,   0, 1, 7));
        // stall with halt pending at pc 7
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 10'h007, 10'd7,   1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 10'h000, 10'd7,   1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 10'h000, 10'd7,   1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 10'h000, 10'd7,   0, 1, 4));
        // wrap 1023 -> 0, then reset mid-RUN at pc 12
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 10'h3FF, 10'd1023, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 10'h00C, 10'd12,  1, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        // start rising in RUN beats halt; stall ignores branch
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd1,   1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 10'h000, 10'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 10'h055, 10'd0,   1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'd1,   1, 0, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Hand-written sequence: jump near the top of the ROM and free-run
        // across the wrap, then halt at the wrapped address.
        pc_m  = 10'd1020;
        cyc_m = 32'd3;
        apply(mk(0, 0, 1, 0, 1, 0, pc_m, pc_m, 1, 0, cyc_m));
        for (int k = 0; k < 6; k++) begin
            pc_m  = pc_m + 10'd1;
            cyc_m = cyc_m + 32'd1;
            apply(mk(0, 0, 0, 0, 0, 0, 10'h000, pc_m, 1, 0, cyc_m));
        end
        cyc_m = cyc_m + 32'd1;
        apply(mk(0, 0, 0, 1, 0, 0, 10'h000, pc_m, 0, 1, cyc_m));
        apply(mk(0, 0, 0, 0, 0, 1, 10'h000, pc_m, 0, 1, cyc_m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the single-cycle 9-bit-instruction CPU. It owns the program counter, sequences fetch from a start handshake through to halt, and applies the control decoder's `Branch`/`Halt` outputs together with the ALU compare result. It sits between the testbench/top-level start/done handshake and the instruction ROM address port.

## Interface
- `D`, 10: program counter width; instruction ROM depth is 2^D.
- `START_ADDR`, 0: PC value loaded on reset and on every re-arm.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; wins over every other input.
- `start`  in  1  level; the run is requested while high and begins on its falling edge.
- `branch`  in  1  from the control decoder `Branch` output for the instruction at `pc`.
- `halt`  in  1  from the control decoder `Halt` output for the instruction at `pc`.
- `taken`  in  1  ALU compare result; 1 means the branch condition holds (bne: operands differ).
- `target`  in  D  absolute branch destination from the branch lookup table.
- `stall`  in  1  holds the PC and suppresses all flow decisions this cycle.
- `pc`  out  D  registered program counter and instruction ROM address.
- `fetch_en`  out  1  high while in RUN; gates register-file and memory writes in the datapath.
- `done`  out  1  registered; high while in HALT.
- `cycles`  out  32  RUN-cycle count; present only with the macro below.

## Operation
- FSM states: IDLE, ARMED, RUN, HALT.
- IDLE: `pc`=START_ADDR. `start`=1 moves to ARMED.
- ARMED: `pc` is forced to START_ADDR. Stays while `start`=1. `start`=0 moves to RUN.
- RUN, `stall`=0, next-PC priority:
  - `halt`=1 → HALT; `pc` holds at the halt instruction address.
  - otherwise `branch`=1 and `taken`=1 → `pc`=`target`.
  - otherwise `pc`=`pc`+1 modulo 2^D. 2^D−1 wraps to 0 with no flag.
- RUN, `stall`=1: `pc` and state hold. `halt`, `branch` and `taken` are ignored.
- `branch`=1 with `taken`=0 behaves as a normal increment.
- HALT: `pc` holds and `done`=1. `start`=1 moves to ARMED, which clears `done` on that edge. No other input leaves HALT.
- `start` rising while in RUN: immediate move to ARMED (abort and re-arm), and `pc`=START_ADDR on that edge.
- `target` is used unmodified. Width is exactly D, with no sign extension or offset.

## Timing
- Reset values:
  - state=IDLE
  - `pc`=START_ADDR
  - `done`=0
  - `fetch_en`=0
  - `cycles`=0
- `pc` is registered. The decision made in cycle n appears on `pc` in cycle n+1, giving one instruction per cycle with no bubbles on taken branches.
- `fetch_en` is a combinational decode of state=RUN and is high starting the first cycle after `start` falls.
- `done` rises on the edge that enters HALT, i.e. the cycle after `halt` is sampled with `stall`=0.
- `halt`, `branch` and `taken` are sampled in the same cycle as the `pc` they refer to. The decoder and ALU are combinational in that path.
- Reset asserted mid-RUN or in HALT returns everything to reset values on the next edge, regardless of `start`/`stall`.
- Simultaneous `halt` and `branch`/`taken`: halt wins.
- Simultaneous `start` rising and `halt` in RUN: `start` wins and the next state is ARMED.

## Configuration
- `PC_SEQ_CYCLE_COUNT_EN` defined:
  - `cycles` port exists as a 32-bit counter.
  - Increments on every clock spent in RUN, stalled cycles included.
  - Saturates at 0xFFFF_FFFF.
  - Cleared on reset and on entry to ARMED.
  - Holds its value in HALT and IDLE so the bench can read it after `done`.
- Not defined: `cycles` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, `start` 1 for 3 cycles then 0, straight-line program with `halt` at address 5 → `pc` steps 0,1,2,3,4,5, holds at 5. `done`=1 one cycle after `halt` is sampled. `cycles`=6 (macro on).
- At `pc`=3: `branch`=1, `taken`=1, `target`=0x2A0 → next `pc`=0x2A0. Repeat with `taken`=0 → next `pc`=4.
- `stall`=1 for 2 cycles at `pc`=7, with `halt`=1 during the stall → `pc` stays 7 and no HALT. `stall` drops with `halt`=1 → HALT with `pc`=7.
- Force `pc` to 1023 (D=10) with no branch → next `pc`=0, still RUN.
- `reset` pulsed for 1 cycle mid-RUN at `pc`=12 → next cycle state IDLE, `pc`=0, `fetch_en`=0, `done`=0, `cycles`=0.
- From HALT, `start` 1 then 0 → `done` clears on the `start` edge, `pc`=0, RUN resumes. `cycles` restarts from 0.
